// File: rtl/phv_out_queue.sv
// rtl/phv_out_queue.sv - per-output-queue PHV buffer, FWFT to the deparser (optional stats: PHV_OUT_QUEUE_STATS_EN)
module phv_out_queue #(
    parameter int PHV_LEN    = 32*64+256,
    parameter int QUEUE_ID   = 0,
    parameter int DEPTH_BITS = 4,
    parameter int AF_MARGIN  = 4
) (
    input  logic                  axis_clk,
    input  logic                  areset,
    input  logic [PHV_LEN-1:0]    phv_in,
    input  logic                  phv_in_valid,
    output logic                  phv_fifo_ready,
    output logic [PHV_LEN-1:0]    phv_out,
    output logic                  phv_out_valid,
    input  logic                  phv_out_ready,
    output logic [DEPTH_BITS:0]   occupancy,
    output logic [31:0]           drop_cnt
);

    localparam int DEPTH     = 1 << DEPTH_BITS;
    localparam int RAM_DEPTH = DEPTH - 1;

    localparam logic [DEPTH_BITS:0]   DEPTH_V  = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0]   AF_LIMIT = (DEPTH_BITS+1)'(DEPTH - AF_MARGIN);
    localparam logic [DEPTH_BITS-1:0] PTR_LAST = DEPTH_BITS'(RAM_DEPTH - 1);

    logic [PHV_LEN-1:0]    ram_q [RAM_DEPTH];
    logic [PHV_LEN-1:0]    out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   occ_q, occ_d;
    logic                  ready_q, ready_d;

    logic queue_ok;
    logic full;
    logic push;
    logic pop;
    logic ram_empty;
    logic out_load;
    logic load_ram;
    logic bypass;
    logic ram_wr;

    function automatic logic [DEPTH_BITS-1:0] ptr_inc(input logic [DEPTH_BITS-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef PHV_OUT_QUEUE_STATS_EN
    assign queue_ok = phv_in[141+QUEUE_ID];
`else
    assign queue_ok = 1'b1;
`endif

    // Full is judged before any same-cycle pop so ready never depends on phv_out_ready.
    assign full      = (occ_q == DEPTH_V);
    assign push      = phv_in_valid && !full && queue_ok;
    assign pop       = out_valid_q && phv_out_ready;
    // Output register holds one entry whenever valid; the rest live in the RAM.
    assign ram_empty = (occ_q == {{DEPTH_BITS{1'b0}}, out_valid_q});
    assign out_load  = !out_valid_q || pop;
    assign load_ram  = out_load && !ram_empty;
    assign bypass    = out_load && ram_empty && push;
    assign ram_wr    = push && !bypass;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        if (load_ram) begin
            out_d       = ram_q[rd_ptr_q];
            out_valid_d = 1'b1;
            rd_ptr_d    = ptr_inc(rd_ptr_q);
        end else if (bypass) begin
            out_d       = phv_in;
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
        if (ram_wr) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        occ_d   = occ_q + {{DEPTH_BITS{1'b0}}, push} - {{DEPTH_BITS{1'b0}}, pop};
        ready_d = (occ_d < AF_LIMIT);
    end

    always_ff @(posedge axis_clk) begin
        if (ram_wr) begin
            ram_q[wr_ptr_q] <= phv_in;
        end
    end

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            ready_q     <= 1'b1;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            ready_q     <= ready_d;
        end
    end

`ifdef PHV_OUT_QUEUE_STATS_EN
    logic [31:0] drop_q, drop_d;
    logic        drop_evt;

    assign drop_evt = phv_in_valid && !push;

    always_comb begin
        drop_d = drop_q;
        if (drop_evt && (drop_q != 32'hFFFF_FFFF)) begin
            drop_d = drop_q + 32'd1;
        end
    end

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

    assign phv_out        = out_q;
    assign phv_out_valid  = out_valid_q;
    assign occupancy      = occ_q;
    assign phv_fifo_ready = ready_q;

endmodule

// File: tb/tb_phv_out_queue.sv
// tb/tb_phv_out_queue.sv - scoreboard bench for phv_out_queue (QUEUE_ID=2, DEPTH_BITS=4, AF_MARGIN=4)
module tb_phv_out_queue;

    localparam int PHV_LEN = 256;
    localparam int QID     = 2;
    localparam int QBIT    = 141 + QID;

    logic               axis_clk;
    logic               areset;
    logic [PHV_LEN-1:0] phv_in;
    logic               phv_in_valid;
    logic               phv_fifo_ready;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_out_valid;
    logic               phv_out_ready;
    logic [4:0]         occupancy;
    logic [31:0]        drop_cnt;

    phv_out_queue #(
        .PHV_LEN   (PHV_LEN),
        .QUEUE_ID  (QID),
        .DEPTH_BITS(4),
        .AF_MARGIN (4)
    ) dut (
        .axis_clk      (axis_clk),
        .areset        (areset),
        .phv_in        (phv_in),
        .phv_in_valid  (phv_in_valid),
        .phv_fifo_ready(phv_fifo_ready),
        .phv_out       (phv_out),
        .phv_out_valid (phv_out_valid),
        .phv_out_ready (phv_out_ready),
        .occupancy     (occupancy),
        .drop_cnt      (drop_cnt)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    int errors = 0;
    int checks = 0;

    logic [PHV_LEN-1:0] sb[$];
    int          occ_m;
    logic        rdy_m;
    logic [31:0] drops_m;
    bit          drain_on;
    int          drain_rx;

`ifdef PHV_OUT_QUEUE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic check(input string tag, input logic [PHV_LEN-1:0] got, input logic [PHV_LEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PHV_LEN-1:0] mk_phv(input int value, input bit qbit);
        logic [PHV_LEN-1:0] p;
        p = '0;
        p[PHV_LEN-1 -: 32] = $urandom;
        p[31:0]            = value;
        p[141]             = ~qbit;
        p[142]             = ~qbit;
        p[144]             = ~qbit;
        p[QBIT]            = qbit;
        return p;
    endfunction

    task automatic model_reset();
        sb.delete();
        occ_m   = 0;
        rdy_m   = 1'b1;
        drops_m = '0;
    endtask

    // Called at a negedge with inputs already driven; checks, then advances one cycle.
    task automatic step();
        bit push_m, pop_m, qok;
        #1;
        check("occupancy", PHV_LEN'(occupancy), PHV_LEN'(occ_m));
        check("fifo_ready", PHV_LEN'(phv_fifo_ready), PHV_LEN'(rdy_m));
        check("out_valid", PHV_LEN'(phv_out_valid), PHV_LEN'(occ_m != 0));
        check("drop_cnt", PHV_LEN'(drop_cnt), PHV_LEN'(drops_m));
        if (occ_m != 0 && sb.size() != 0)
            check("head_data", phv_out, sb[0]);
        qok    = STATS ? phv_in[QBIT] : 1'b1;
        push_m = phv_in_valid && (occ_m < 16) && qok;
        pop_m  = (occ_m != 0) && phv_out_ready;
        if (pop_m && drain_on) begin
            check("drain_order", PHV_LEN'(phv_out[31:0]), PHV_LEN'(drain_rx));
            drain_rx++;
        end
        if (pop_m && sb.size() != 0) void'(sb.pop_front());
        if (push_m) sb.push_back(phv_in);
        if (STATS && phv_in_valid && !push_m && drops_m != 32'hFFFF_FFFF) drops_m++;
        occ_m = occ_m + int'(push_m) - int'(pop_m);
        rdy_m = (occ_m < 12);
        @(posedge axis_clk);
        @(negedge axis_clk);
    endtask

    initial begin
        logic [PHV_LEN-1:0] held;
        int n;

        areset        = 1'b1;
        phv_in        = '0;
        phv_in_valid  = 1'b0;
        phv_out_ready = 1'b0;
        drain_on      = 1'b0;
        drain_rx      = 0;
        model_reset();
        repeat (3) @(negedge axis_clk);
        #1;
        check("rst_out", phv_out, '0);
        check("rst_valid", PHV_LEN'(phv_out_valid), '0);
        check("rst_occ", PHV_LEN'(occupancy), '0);
        check("rst_drop", PHV_LEN'(drop_cnt), '0);
        check("rst_ready", PHV_LEN'(phv_fifo_ready), PHV_LEN'(1));
        @(negedge axis_clk);
        areset = 1'b0;

        // single PHV, one-cycle latency, then drains
        phv_out_ready = 1'b1;
        phv_in        = mk_phv(32'h0000_00A5, 1'b1);
        held          = phv_in;
        phv_in_valid  = 1'b1;
        step();
        phv_in_valid = 1'b0;
        check("lat1_valid", PHV_LEN'(phv_out_valid), PHV_LEN'(1));
        check("lat1_data", phv_out, held);
        step();
        check("single_occ0", PHV_LEN'(occupancy), '0);

        // burst of 16 with the deparser stalled
        phv_out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            phv_in       = mk_phv(32'h100 + i, 1'b1);
            phv_in_valid = 1'b1;
            step();
            if (i == 10) check("ready_after_11", PHV_LEN'(phv_fifo_ready), PHV_LEN'(1));
            if (i == 11) check("ready_after_12", PHV_LEN'(phv_fifo_ready), '0);
        end
        check("burst_occ16", PHV_LEN'(occupancy), PHV_LEN'(16));

        // push at full with a simultaneous pop: push is dropped
        phv_in        = mk_phv(32'h1FF, 1'b1);
        phv_in_valid  = 1'b1;
        phv_out_ready = 1'b1;
        step();
        phv_in_valid = 1'b0;
        check("full_push_occ", PHV_LEN'(occupancy), PHV_LEN'(15));
        check("full_push_drop", PHV_LEN'(drop_cnt), STATS ? PHV_LEN'(1) : '0);
        repeat (16) step();
        check("empty_before_drain", PHV_LEN'(occupancy), '0);

        // 40 ordered PHVs under random backpressure; stall stability via head_data
        drain_on = 1'b1;
        n = 0;
        for (int c = 0; c < 800 && drain_rx < 40; c++) begin
            phv_out_ready = 1'($urandom_range(0, 1));
            if (n < 40 && occ_m < 16 && $urandom_range(0, 3) != 0) begin
                phv_in       = mk_phv(n, 1'b1);
                phv_in_valid = 1'b1;
                n++;
            end else begin
                phv_in_valid = 1'b0;
            end
            step();
        end
        drain_on     = 1'b0;
        phv_in_valid = 1'b0;
        check("drain_count", PHV_LEN'(drain_rx), PHV_LEN'(40));

        // mis-steered PHV
        phv_out_ready = 1'b0;
        phv_in        = mk_phv(32'h2AA, 1'b0);
        phv_in_valid  = 1'b1;
        step();
        phv_in_valid = 1'b0;
        check("missteer_occ", PHV_LEN'(occupancy), STATS ? '0 : PHV_LEN'(1));
        check("missteer_drop", PHV_LEN'(drop_cnt), STATS ? PHV_LEN'(2) : '0);
        phv_out_ready = 1'b1;
        repeat (3) step();

        // reset pulsed mid-burst
        phv_out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            phv_in       = mk_phv(32'h300 + i, 1'b1);
            phv_in_valid = 1'b1;
            step();
        end
        phv_in_valid = 1'b0;
        check("midrst_occ7", PHV_LEN'(occupancy), PHV_LEN'(7));
        #2 areset = 1'b1;
        #1;
        check("async_rst_valid", PHV_LEN'(phv_out_valid), '0);
        check("async_rst_occ", PHV_LEN'(occupancy), '0);
        check("async_rst_ready", PHV_LEN'(phv_fifo_ready), PHV_LEN'(1));
        model_reset();
        #1 areset = 1'b0;
        @(negedge axis_clk);
        phv_out_ready = 1'b1;
        phv_in        = mk_phv(32'h4CC, 1'b1);
        held          = phv_in;
        phv_in_valid  = 1'b1;
        step();
        phv_in_valid = 1'b0;
        check("post_rst_valid", PHV_LEN'(phv_out_valid), PHV_LEN'(1));
        check("post_rst_data", phv_out, held);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
